fir_tap_mac: RTL and testbench
==============================

# fir_tap_mac

Time-multiplexed 64-tap FIR multiply-accumulate stage for one equalizer band. It sits directly downstream of the 6-bit phase counter and consumes its `current_count`/`phase_0` outputs to sequence one tap per enabled cycle. It accepts one audio sample per 64-count frame and produces one filtered, rounded sample per frame. The coefficient for the current tap is read from an external combinational coefficient table indexed by `current_count`.

## Interface
- `DATA_W`, 16, signed sample width, input and output
- `COEF_W`, 16, signed Q1.15 coefficient width
- `ACC_W`, 38, accumulator width (DATA_W+COEF_W+6)
- `clk` input 1 — single system clock
- `rst` input 1 — asynchronous, active-high reset
- `clk_enable` input 1 — advance enable, same signal that drives the phase counter
- `current_count` input 6 — tap index k, 0..63, from the phase counter
- `phase_0` input 1 — high when k==0 and `clk_enable`=1; marks the sample-capture cycle
- `filter_in` input DATA_W — signed sample, sampled only when `phase_0`=1
- `coeff` input COEF_W — signed coefficient h[current_count], combinational from the table
- `filter_out` output DATA_W — signed filtered sample, held between updates
- `out_valid` output 1 — one-`clk` pulse when `filter_out` updates

## Operation
- Delay line: 64×DATA_W circular buffer with 6-bit base pointer `b`. On a `phase_0` edge: `mem[b-1] <= filter_in` and `b <= b-1` (mod 64).
- Tap operand x(k): for k=0, `filter_in` (bypass); for k≥1, `mem[(b+k) mod 64]`, using the already-updated `b`.
- Stage 1, on each enabled edge:
  - `p_reg <= coeff * x(k)`, full-precision signed, 32 bits.
  - `k_reg <= k`.
  - `p_vld <= 1`.
- Stage 2, on each enabled edge with `p_vld`=1:
  - If `k_reg`==0: `acc <= sext(p_reg)`.
  - Otherwise: `acc <= acc + sext(p_reg)`.
  - If `k_reg`==63: compute `sum = acc + p_reg`, then `r = (sum + 2^14) >>> 15` (round half up), reduce `r` to DATA_W per Configuration, register the result to `filter_out`, and pulse `out_valid`.
- The accumulator is ACC_W wide and never overflows for 64 taps.
- With `clk_enable`=0, no state changes. `out_valid` still deasserts on the next `clk`.
- Stage 1 ignores `current_count` unless `clk_enable`=1.

## Timing
- Reset values are all zero: `filter_out`, `out_valid`, `acc`, `p_reg`, `k_reg`, `p_vld`, `b`, and all 64 delay-line entries.
- Latency: a sample captured on the `phase_0` edge of frame n contributes to the `filter_out` produced on the `phase_0` edge of frame n+1. That is 64 enabled cycles.
- `out_valid` is high for exactly one `clk` after that edge.
- First output after reset: the second `phase_0` edge. The first `phase_0` finds `p_vld`=0 and produces no output.
- Reset mid-frame: all state clears immediately, partial sums and samples are discarded, and the upstream counter restarts from 0 under the same `rst`.
- Tap sequencing assumes `current_count` increments by 1 per enabled cycle and wraps 63→0. Any other sequence is unsupported.
- Pointer wrap: `b` is mod 64, so 0−1 → 63.

## Configuration
- `FIR_TAP_MAC_SAT_EN` defined: `r` is clamped to [−32768, 32767] before registering.
- `FIR_TAP_MAC_SAT_EN` undefined: `r` is truncated to its low DATA_W bits (two's-complement wrap).

## Structure
- Shared package `eq_pkg` holds:
  - `DATA_W`, `COEF_W`, `ACC_W`
  - `TAPS=64`
  - `ROUND_CONST=2**14`, `FRAC_BITS=15`
  - `sample_t`, `coef_t`, `acc_t` typedefs
- Sub-module `fir_delay_line` implements the circular buffer, the base pointer, and the k=0 bypass, and outputs x(k).
- MAC pipeline, rounding and saturation stay in `fir_tap_mac`.

## Test plan
- Impulse: `filter_in`=32767 in frame 0 then 0, with h[k]=k·256 → frame-j output (j=0..63) = round(32767·j·256/32768). The j=1 output is 256. `out_valid` pulses once per frame.
- DC: `filter_in`=1000 constant, all h=512 → output ramps up and settles at 1000 from the 64th output onward.
- Overflow: `filter_in`=32767 constant, all h=32767 → steady output 32767 with `FIR_TAP_MAC_SAT_EN`, and −128 (0xFF80) without it.
- Negative corner: `filter_in`=−32768, h[0]=−32768, other taps 0 → output 32767 with SAT_EN, and −32768 without it.
- Enable gating: `clk_enable` toggling every other `clk` → same output sequence as the DC case, `out_valid` spaced 128 `clk`, each pulse one `clk` wide.
- Reset at count 30 mid-frame → `filter_out`=0 and `out_valid`=0 immediately. No output at the first post-reset `phase_0`. The next output equals the response to a zeroed history.

Source files
------------

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared widths, types and rounding helpers for the equalizer FIR band
package eq_pkg;

  localparam int DATA_W      = 16;
  localparam int COEF_W      = 16;
  localparam int PROD_W      = DATA_W + COEF_W;
  localparam int ACC_W       = DATA_W + COEF_W + 6;
  localparam int TAPS        = 64;
  localparam int TAP_W       = $clog2(TAPS);
  localparam int ROUND_CONST = 2**14;
  localparam int FRAC_BITS   = 15;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic        [TAP_W-1:0]  tap_t;

  localparam tap_t    LAST_TAP   = tap_t'(TAPS - 1);
  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam acc_t    SAT_HI     = acc_t'(SAMPLE_MAX);
  localparam acc_t    SAT_LO     = acc_t'(SAMPLE_MIN);

  // Q1.15 products back to sample scale, ties rounded toward +inf
  function automatic acc_t round_shift(acc_t sum);
    acc_t biased;
    biased = sum + acc_t'(ROUND_CONST);
    return biased >>> FRAC_BITS;
  endfunction

  function automatic sample_t clamp_sample(acc_t r);
    if (r > SAT_HI) return SAMPLE_MAX;
    if (r < SAT_LO) return SAMPLE_MIN;
    return sample_t'(r);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - 64-entry circular sample history with tap-0 bypass
module fir_delay_line
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     phase_0,
  input  logic        [TAP_W-1:0]  current_count,
  input  logic signed [DATA_W-1:0] filter_in,
  output logic signed [DATA_W-1:0] tap_sample
);

  sample_t mem [TAPS];
  tap_t    base;
  tap_t    wr_ptr;
  tap_t    rd_ptr;

  // Writing one slot below the base makes the newest sample sit at base,
  // so tap k lives at base+k with no data movement.
  assign wr_ptr = base - tap_t'(1);
  assign rd_ptr = base + current_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      mem  <= '{default: '0};
    end else if (clk_enable && phase_0) begin
      mem[wr_ptr] <= filter_in;
      base        <= wr_ptr;
    end
  end

  // Tap 0 is consumed on the same edge that stores it, hence the bypass
  assign tap_sample = (current_count == '0) ? filter_in : mem[rd_ptr];

endmodule

// File: rtl/fir_tap_mac.sv
// rtl/fir_tap_mac.sv - time-multiplexed 64-tap FIR MAC, one rounded output per frame.
// Define FIR_TAP_MAC_SAT_EN to clamp the output instead of wrapping it.
module fir_tap_mac
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic        [TAP_W-1:0]  current_count,
  input  logic                     phase_0,
  input  logic signed [DATA_W-1:0] filter_in,
  input  logic signed [COEF_W-1:0] coeff,
  output logic signed [DATA_W-1:0] filter_out,
  output logic                     out_valid
);

  sample_t x_k;
  prod_t   prod;
  prod_t   p_reg;
  tap_t    k_reg;
  logic    p_vld;
  acc_t    acc;
  acc_t    p_ext;
  acc_t    sum;
  acc_t    rounded;
  sample_t result;

  fir_delay_line u_delay_line (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .phase_0       (phase_0),
    .current_count (current_count),
    .filter_in     (filter_in),
    .tap_sample    (x_k)
  );

  assign prod    = prod_t'(coeff) * prod_t'(x_k);
  assign p_ext   = acc_t'(p_reg);
  assign sum     = acc + p_ext;
  assign rounded = round_shift(sum);

  always_comb begin
`ifdef FIR_TAP_MAC_SAT_EN
    result = clamp_sample(rounded);
`else
    result = sample_t'(rounded);
`endif
  end

  // The last tap's product is folded in combinationally so the frame result
  // lands on the phase_0 edge rather than one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg      <= '0;
      k_reg      <= '0;
      p_vld      <= 1'b0;
      acc        <= '0;
      filter_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clk_enable) begin
        p_reg <= prod;
        k_reg <= current_count;
        p_vld <= 1'b1;
        if (p_vld) begin
          acc <= (k_reg == '0) ? p_ext : sum;
          if (k_reg == LAST_TAP) begin
            filter_out <= result;
            out_valid  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_mac.sv
// tb/tb_fir_tap_mac.sv - self-checking bench for fir_tap_mac against a frame-level FIR model
module tb_fir_tap_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_enable;
  logic               phase_0;
  logic        [5:0]  current_count;
  logic signed [15:0] filter_in;
  logic signed [15:0] coeff;
  logic signed [15:0] filter_out;
  logic               out_valid;

  fir_tap_mac dut (
    .clk           (clk),
    .rst           (rst),
    .clk_enable    (clk_enable),
    .current_count (current_count),
    .phase_0       (phase_0),
    .filter_in     (filter_in),
    .coeff         (coeff),
    .filter_out    (filter_out),
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    hmode;
    int    hval;
    int    sample;
    int    frames;
    int    expect_out;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic signed [15:0] h    [64];
  logic signed [15:0] hist [64];
  logic signed [15:0] exp_out;
  logic signed [15:0] next_out;
  logic signed [15:0] cur_sample;
  logic signed [15:0] outs [$];
  bit exp_valid;
  bit pending;
  int cnt;
  int cyc;
  int last_pulse;
  int pulse_gap;
  int pulses;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct convolution of the sample history with the coefficient table
  function automatic logic signed [15:0] ref_out();
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < 64; k++) s += longint'(h[k]) * longint'(hist[k]);
    r = (s + 16384) >>> 15;
`ifdef FIR_TAP_MAC_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) hist[i] = '0;
    cnt       = 0;
    pending   = 0;
    exp_out   = '0;
    next_out  = '0;
    exp_valid = 0;
  endtask

  task automatic step(input bit en);
    clk_enable    = en;
    current_count = 6'(cnt);
    phase_0       = en && (cnt == 0);
    coeff         = h[cnt];
    filter_in     = (cnt == 0) ? cur_sample : 16'($urandom);
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 0;
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (cnt == 0) begin
        exp_valid = pending;
        if (pending) exp_out = next_out;
        for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
        hist[0]  = cur_sample;
        next_out = ref_out();
        pending  = 1;
      end
      cnt = (cnt + 1) % 64;
    end
    check("out_valid", out_valid, exp_valid);
    check("filter_out", filter_out, exp_out);
    if (out_valid) begin
      pulse_gap  = cyc - last_pulse;
      last_pulse = cyc;
      pulses++;
      outs.push_back(filter_out);
    end
  endtask

  // mode 0: always enabled, 1: enable every other clk, 2: random enable
  task automatic run_frame(input logic signed [15:0] s, input int mode);
    int done;
    bit en;
    cur_sample = s;
    done = 0;
    while (done < 64) begin
      en = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
      step(en);
      if (en) done++;
      if (mode == 1) step(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst    = 1'b0;
    pulses = 0;
    outs.delete();
  endtask

  task automatic set_coeffs(input int mode, input int val);
    for (int k = 0; k < 64; k++) begin
      case (mode)
        0:       h[k] = 16'(val);
        1:       h[k] = (k == 0) ? 16'(val) : 16'sd0;
        2:       h[k] = 16'(k * 256);
        3:       h[k] = 16'($urandom);
        default: h[k] = 16'($urandom_range(4095)) - 16'sd2048;
      endcase
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_enable = 1'b0; phase_0 = 1'b0; current_count = '0;
    filter_in = '0; coeff = '0; cur_sample = '0;
    cyc = 0; last_pulse = 0; pulse_gap = 0; pulses = 0;
    for (int k = 0; k < 64; k++) h[k] = '0;
    model_reset();

    vecs[0] = '{"dc_pos",         0, 512,    1000,   66, 1000};
    vecs[1] = '{"dc_neg",         0, 512,    -1000,  66, -1000};
`ifdef FIR_TAP_MAC_SAT_EN
    vecs[2] = '{"overflow",       0, 32767,  32767,  66, 32767};
    vecs[3] = '{"neg_corner",     1, -32768, -32768, 3,  32767};
`else
    vecs[2] = '{"overflow",       0, 32767,  32767,  66, -128};
    vecs[3] = '{"neg_corner",     1, -32768, -32768, 3,  -32768};
`endif
    vecs[4] = '{"round_half_up",  1, 16384,  1,      3,  1};
    vecs[5] = '{"round_neg_half", 1, 16384,  -1,     3,  0};

    do_reset();
    check("reset_filter_out", filter_out, 0);
    check("reset_out_valid", out_valid, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_coeffs(vecs[v].hmode, vecs[v].hval);
      for (int f = 0; f < vecs[v].frames; f++) run_frame(16'(vecs[v].sample), 0);
      check(vecs[v].name, filter_out, vecs[v].expect_out);
      check({vecs[v].name, "_pulses"}, pulses, vecs[v].frames - 1);
    end

    // Impulse through a ramp of coefficients
    do_reset();
    set_coeffs(2, 0);
    run_frame(16'sd32767, 0);
    for (int f = 1; f < 65; f++) run_frame(16'sd0, 0);
    check("impulse_count", outs.size(), 64);
    check("impulse_j1", (outs.size() > 1) ? longint'(outs[1]) : -1, 256);
    for (int j = 0; j < 64 && j < outs.size(); j++)
      check($sformatf("impulse_%0d", j), outs[j], (longint'(32767) * j * 256 + 16384) / 32768);

    // DC with clk_enable every other clk
    do_reset();
    set_coeffs(0, 512);
    for (int f = 0; f < 66; f++) begin
      run_frame(16'sd1000, 1);
      if (pulses >= 2) check("gate_spacing", pulse_gap, 128);
    end
    check("gate_settle", filter_out, 1000);
    check("gate_pulses", pulses, 65);

    // Asynchronous reset at count 30
    do_reset();
    set_coeffs(0, 512);
    for (int f = 0; f < 3; f++) run_frame(16'sd1000, 0);
    cur_sample = 16'sd1000;
    while (cnt != 30) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", filter_out, 0);
    check("async_rst_valid", out_valid, 0);
    model_reset();
    step(1'b0);
    rst    = 1'b0;
    pulses = 0;
    run_frame(16'sd1000, 0);
    check("post_rst_no_output", pulses, 0);
    run_frame(16'sd0, 0);
    check("post_rst_first", filter_out, 16);
    check("post_rst_pulses", pulses, 1);

    // Randomized coefficients, samples and enable pattern
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      set_coeffs(3 + pass, 0);
      for (int f = 0; f < 10; f++) run_frame(16'($urandom), 2);
      check("rand_pulses", pulses, 9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
